// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load port and back-to-back framing.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;

    assign last       = (state == SHIFT) && (cnt == LAST_CNT);
    // Output end is bit 0 for LSB-first, bit WIDTH-1 otherwise; vacated bits fill with 0.
    assign shreg_next = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

`ifdef PISO_PARITY_EN
    assign load_ready = (state == IDLE) || ((state == PARITY) && shift_en);
    assign frame_done = (state == PARITY) && shift_en;
`else
    assign load_ready = (state == IDLE) || (last && shift_en);
    assign frame_done = last && shift_en;
`endif

    assign accept      = load_valid && load_ready;
    assign ser_valid   = (state != IDLE);
    assign busy        = (state != IDLE);
    assign frame_start = (state == SHIFT) && (cnt == '0);

    always_comb begin
        ser_out = 1'b0;
        case (state)
            SHIFT:   ser_out = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
`ifdef PISO_PARITY_EN
            PARITY:  ser_out = par;
`endif
            default: ser_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            // Also covers the back-to-back case: the new word replaces the finishing one.
            state <= SHIFT;
            shreg <= load_data;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= ^load_data;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (shift_en) begin
                        shreg <= shreg_next;
                        if (last) begin
                            cnt   <= '0;
`ifdef PISO_PARITY_EN
                            state <= PARITY;
`else
                            state <= IDLE;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    if (shift_en) state <= IDLE;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: per-cycle vector table plus hand sequences
// for MSB-first ordering, reset abort and reset/load collision.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid, shift_en;
    logic [3:0] load_data;
    logic       load_ready, ser_out, ser_valid, frame_start, frame_done, busy;

    logic       m_load_valid, m_shift_en;
    logic [3:0] m_load_data;
    logic       m_load_ready, m_ser_out, m_ser_valid, m_frame_start, m_frame_done, m_busy;
    logic [3:0] sr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .shift_en(shift_en), .ser_out(ser_out), .ser_valid(ser_valid),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset),
        .load_valid(m_load_valid), .load_ready(m_load_ready), .load_data(m_load_data),
        .shift_en(m_shift_en), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
        .frame_start(m_frame_start), .frame_done(m_frame_done), .busy(m_busy)
    );

    // Downstream serial-in right-shift register fed from the MSB-first instance.
    always @(posedge clk) begin
        if (reset) sr <= 4'h0;
        else if (m_ser_valid && m_shift_en) sr <= {m_ser_out, sr[3:1]};
    end

    // Packed outputs: {ser_out, ser_valid, frame_start, frame_done, busy, load_ready}
    typedef struct {
        string      tag;
        logic       lv;
        logic [3:0] data;
        logic       se;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [5:0] outs();
        return {ser_out, ser_valid, frame_start, frame_done, busy, load_ready};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input string tag, input logic lv, input logic [3:0] d,
                       input logic se, input logic [5:0] exp);
        vec_t v;
        v.tag = tag; v.lv = lv; v.data = d; v.se = se; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive at the negedge, sample 1 ns later, then move to the next negedge.
    task automatic cyc(input logic lv, input logic [3:0] d, input logic se, input logic rst);
        load_valid = lv; load_data = d; shift_en = se; reset = rst;
        #1;
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_data = 4'h0; shift_en = 1'b1;
        m_load_valid = 1'b0; m_load_data = 4'h0; m_shift_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_outs", {2'b0, outs()}, 8'b0000_0001);

`ifdef PISO_PARITY_EN
        // T6: 0111 -> 1,1,1,0 then parity 1; frame_done and load_ready on the 5th bit
        add("t6_c0", 1, 4'b0111, 1, 6'b000001);
        add("t6_c1", 0, 4'h0,    1, 6'b111010);
        add("t6_c2", 0, 4'h0,    1, 6'b110010);
        add("t6_c3", 0, 4'h0,    1, 6'b110010);
        add("t6_c4", 0, 4'h0,    1, 6'b010010);
        add("t6_c5", 0, 4'h0,    1, 6'b110111);
        add("t6_c6", 0, 4'h0,    1, 6'b000001);
`else
        // T1: 1011 LSB-first -> 1,1,0,1
        add("t1_c0", 1, 4'b1011, 1, 6'b000001);
        add("t1_c1", 0, 4'h0,    1, 6'b111010);
        add("t1_c2", 0, 4'h0,    1, 6'b110010);
        add("t1_c3", 0, 4'h0,    1, 6'b010010);
        add("t1_c4", 0, 4'h0,    1, 6'b110111);
        add("t1_c5", 0, 4'h0,    1, 6'b000001);
        // T3: A then 5 back-to-back -> 0,1,0,1,1,0,1,0 with no gap
        add("t3_c0", 1, 4'hA, 1, 6'b000001);
        add("t3_c1", 1, 4'h5, 1, 6'b011010);
        add("t3_c2", 1, 4'h5, 1, 6'b110010);
        add("t3_c3", 1, 4'h5, 1, 6'b010010);
        add("t3_c4", 1, 4'h5, 1, 6'b110111);
        add("t3_c5", 0, 4'h0, 1, 6'b111010);
        add("t3_c6", 0, 4'h0, 1, 6'b010010);
        add("t3_c7", 0, 4'h0, 1, 6'b110010);
        add("t3_c8", 0, 4'h0, 1, 6'b010111);
        add("t3_c9", 0, 4'h0, 1, 6'b000001);
        // T4: 0110 with a 3-cycle stall on bit 2; load attempts while not ready are ignored
        add("t4_c0", 1, 4'b0110, 1, 6'b000001);
        add("t4_c1", 0, 4'h0,    1, 6'b011010);
        add("t4_c2", 1, 4'hF,    0, 6'b110010);
        add("t4_c3", 1, 4'hF,    0, 6'b110010);
        add("t4_c4", 0, 4'h0,    0, 6'b110010);
        add("t4_c5", 0, 4'h0,    1, 6'b110010);
        add("t4_c6", 0, 4'h0,    1, 6'b110010);
        add("t4_c7", 0, 4'h0,    1, 6'b010111);
        add("t4_c8", 0, 4'h0,    1, 6'b000001);
`endif

        foreach (vecs[i]) begin
            cyc(vecs[i].lv, vecs[i].data, vecs[i].se, 1'b0);
            check(vecs[i].tag, {2'b0, outs()}, {2'b0, vecs[i].exp});
            @(negedge clk);
        end

`ifndef PISO_PARITY_EN
        // T2: MSB-first 1011 -> 1,0,1,1; downstream register ends at 1101
        begin
            logic [3:0] exp_bits;
            exp_bits = 4'b1011;
            m_load_valid = 1'b1; m_load_data = 4'b1011;
            @(negedge clk);
            m_load_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                #1;
                check($sformatf("t2_bit%0d", k), {7'b0, m_ser_out}, {7'b0, exp_bits[3-k]});
                check($sformatf("t2_fdone%0d", k), {7'b0, m_frame_done}, {7'b0, k == 3});
                @(negedge clk);
            end
            #1;
            check("t2_sr", {4'b0, sr}, 8'h0D);
            check("t2_idle", {6'b0, m_busy, m_load_ready}, 8'b01);
            @(negedge clk);
        end

        // T5: reset after bit 2 of F, then a clean 1001 frame
        cyc(1, 4'hF, 1, 0);   @(negedge clk);
        cyc(0, 4'h0, 1, 0);   check("t5_bit1", {2'b0, outs()}, 8'b0011_1010);
        @(negedge clk);
        cyc(0, 4'h0, 1, 1);   check("t5_bit2", {2'b0, outs()}, 8'b0011_0010);
        @(negedge clk);
        cyc(1, 4'h9, 1, 0);   check("t5_after_rst", {2'b0, outs()}, 8'b0000_0001);
        @(negedge clk);
        cyc(0, 4'h0, 1, 0);   check("t5_new_b0", {2'b0, outs()}, 8'b0011_1010);
        @(negedge clk);
        cyc(0, 4'h0, 1, 0);   check("t5_new_b1", {2'b0, outs()}, 8'b0001_0010);
        @(negedge clk);
        cyc(0, 4'h0, 1, 0);   check("t5_new_b2", {2'b0, outs()}, 8'b0001_0010);
        @(negedge clk);
        cyc(0, 4'h0, 1, 0);   check("t5_new_b3", {2'b0, outs()}, 8'b0011_0111);
        @(negedge clk);
        // Reset and load on the same edge: the word must be dropped
        cyc(1, 4'hF, 1, 1);
        @(negedge clk);
        cyc(0, 4'h0, 1, 0);   check("rst_vs_load", {2'b0, outs()}, 8'b0000_0001);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
